pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Responder side of the hazard interface: consumes the hazard unit's load-use Stall request, the ID-stage redirect (taken branch/jump) and the data-memory busy signal.
- Drives the per-stage enable, flush and bubble controls of the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Sequences multi-cycle freezes and redirect flushes with a small FSM.
- Carries a stall watchdog and optional performance counters.

Parameters:
- FLUSH_CYCLES, 1: number of cycles IF/ID is flushed after an accepted redirect. Legal range 1..7.
- MAX_STALL, 15: number of consecutive Stall cycles after which the watchdog error is set. Legal range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk in 1: pipeline clock.
- rst in 1: reset, asynchronous, active-high; all state is cleared on assertion.
- stall_req in 1: load-use stall from the hazard unit, combinational, same cycle.
- redirect in 1: ID stage resolved a taken branch or jump.
- dmem_busy in 1: data memory has not completed the MEM-stage access.
- pc_en out 1: PC register load enable.
- pc_sel_redirect out 1: PC mux selects the redirect target.
- ifid_en out 1: IF/ID register enable.
- ifid_flush out 1: IF/ID loads a NOP.
- idex_en out 1: ID/EX register enable.
- idex_bubble out 1: ID/EX loads a bubble (all control signals zero).
- exmem_en out 1: EX/MEM register enable.
- memwb_en out 1: MEM/WB register enable.
- state out 2: FSM state. 00 RUN, 01 STALL, 10 FLUSH, 11 MEMWAIT.
- wdog_err out 1: sticky watchdog error.

Behaviour:
- Reset values: state=RUN, wdog_err=0, internal counters=0. Outputs decode from state and inputs, giving pc_en=ifid_en=idex_en=exmem_en=memwb_en=1 and all flush/bubble/sel outputs=0 (with inputs low).
- Priority each cycle: dmem_busy > stall_req > redirect > normal.
- dmem_busy=1, any state:
  - all five enables=0; no flush, no bubble; pc_sel_redirect=0.
  - Next state=MEMWAIT.
  - Saved state: the FSM holds the pending FLUSH remaining count. Redirect and stall_req are ignored while dmem_busy=1.
- MEMWAIT and dmem_busy=0: resume to FLUSH if flush cycles remain, else RUN. Evaluate the current inputs as in RUN in that same cycle.
- stall_req=1, dmem_busy=0:
  - pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exmem_en=memwb_en=1.
  - State=STALL.
  - A redirect in this cycle is ignored; the branch is re-resolved after the stall.
- STALL and stall_req=0: return to RUN and apply the RUN rules to this cycle's inputs.
- Watchdog:
  - An 8-bit consecutive-stall counter increments per STALL cycle and clears on any non-stall cycle. MEMWAIT cycles neither count nor clear it.
  - When the counter reaches MAX_STALL, wdog_err is set to 1 and held until rst.
- redirect=1, no stall or busy, in RUN:
  - pc_en=1, pc_sel_redirect=1, ifid_flush=1, ifid_en=1, other enables=1.
  - If FLUSH_CYCLES>1: enter FLUSH with remaining=FLUSH_CYCLES-1.
- FLUSH:
  - ifid_flush=1, pc_en=1, pc_sel_redirect=0.
  - remaining decrements per non-busy cycle; leave to RUN when it reaches 0.
  - redirect inputs are ignored while in FLUSH, because the instruction in ID is a flushed NOP.
- stall_req asserted while in FLUSH: stall takes priority for that cycle (ifid_flush=0, bubble applied). remaining is not decremented.
- Latency: all control outputs are combinational from the current state and inputs, with zero-cycle response. State updates on posedge clk.
- Reset mid-operation (any state, including MEMWAIT): immediate return to RUN. The flush count and stall counter are cleared; wdog_err=0.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall, perf_flush and perf_memwait, each CNT_W bits.
  - They count STALL cycles, cycles with ifid_flush=1, and cycles with dmem_busy=1 respectively.
  - Each saturates at all-ones and clears on rst.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with dmem_busy=1 -> outputs go immediately to state=00, all enables=1, wdog_err=0.
- Load-use: stall_req=1 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_bubble=1, state=01. Next cycle all enables=1, state=00.
- Redirect with FLUSH_CYCLES=2: redirect=1 one cycle -> cycle0 pc_sel_redirect=1, ifid_flush=1. Cycle1 state=10, ifid_flush=1, pc_sel_redirect=0. Cycle2 state=00, ifid_flush=0.
- Priority: stall_req=1, redirect=1, dmem_busy=1 together for 3 cycles -> all enables=0, state=11, no flush. Then dmem_busy=0 with stall_req=1 -> state=01, idex_bubble=1, pc_sel_redirect=0.
- Watchdog with MAX_STALL=15: stall_req held 14 cycles -> wdog_err=0. Held to 15 cycles -> wdog_err=1, which remains 1 after stall_req drops, until rst.
- With PIPE_CTRL_PERF_EN: 3 stall cycles, 1 redirect (FLUSH_CYCLES=1), 4 busy cycles -> perf_stall=3, perf_flush=1, perf_memwait=4.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Hazard/pipeline-control bundle between the hazard unit side (master)
// and pipe_ctrl (slave). Perf counter signals exist only when
// PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_req;
    logic             redirect;
    logic             dmem_busy;
    logic             pc_en;
    logic             pc_sel_redirect;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             exmem_en;
    logic             memwb_en;
    logic [1:0]       state;
    logic             wdog_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall;
    logic [CNT_W-1:0] perf_flush;
    logic [CNT_W-1:0] perf_memwait;

    modport master (
        output stall_req, redirect, dmem_busy,
        input  pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en,
               idex_bubble, exmem_en, memwb_en, state, wdog_err,
               perf_stall, perf_flush, perf_memwait
    );
    modport slave (
        input  stall_req, redirect, dmem_busy,
        output pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en,
               idex_bubble, exmem_en, memwb_en, state, wdog_err,
               perf_stall, perf_flush, perf_memwait
    );
`else
    modport master (
        output stall_req, redirect, dmem_busy,
        input  pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en,
               idex_bubble, exmem_en, memwb_en, state, wdog_err
    );
    modport slave (
        input  stall_req, redirect, dmem_busy,
        output pc_en, pc_sel_redirect, ifid_en, ifid_flush, idex_en,
               idex_bubble, exmem_en, memwb_en, state, wdog_err
    );
`endif
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline freeze/flush/bubble controller.
// Priority per cycle: dmem_busy > stall_req > pending flush > redirect.
// The o-state reported on bus.state is the mode the pipeline is in this
// cycle (combinational, zero latency); r_state holds the mode carried
// into the next cycle. Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // 1..7
    parameter int MAX_STALL    = 15,  // 1..255
    parameter int CNT_W        = 32
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, MEMWAIT = 2'b11} state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_eff;
    logic [2:0] r_rem;
    logic [2:0] w_rem_nxt;
    logic [7:0] r_stall_cnt;
    logic       r_wdog;
    logic       w_busy, w_stall, w_redir, w_flush_pend;

    // While rst is held the pipeline runs freely, regardless of inputs.
    assign w_busy       = bus.dmem_busy & ~rst;
    assign w_stall      = bus.stall_req & ~rst;
    assign w_redir      = bus.redirect  & ~rst;
    // A flush interrupted by a stall or a memory wait keeps its count.
    assign w_flush_pend = (r_state != RUN) && (r_rem != 3'd0);

    // State register and remaining-flush count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_next;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state / effective-mode decode for this cycle
    always_comb begin
        w_eff     = RUN;
        w_next    = RUN;
        w_rem_nxt = r_rem;
        if (w_busy) begin
            w_eff  = MEMWAIT;
            w_next = MEMWAIT;
        end else if (w_stall) begin
            w_eff  = STALL;
            w_next = STALL;
        end else if (w_flush_pend) begin
            w_eff     = FLUSH;
            w_rem_nxt = r_rem - 3'd1;
            w_next    = (r_rem == 3'd1) ? RUN : FLUSH;
        end else if (w_redir) begin
            w_rem_nxt = 3'(FLUSH_CYCLES - 1);
            w_next    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end
    end

    // Output decode from the effective mode and redirect
    always_comb begin
        bus.pc_en           = 1'b1;
        bus.pc_sel_redirect = 1'b0;
        bus.ifid_en         = 1'b1;
        bus.ifid_flush      = 1'b0;
        bus.idex_en         = 1'b1;
        bus.idex_bubble     = 1'b0;
        bus.exmem_en        = 1'b1;
        bus.memwb_en        = 1'b1;
        bus.state           = w_eff;
        case (w_eff)
            MEMWAIT: begin
                bus.pc_en    = 1'b0;
                bus.ifid_en  = 1'b0;
                bus.idex_en  = 1'b0;
                bus.exmem_en = 1'b0;
                bus.memwb_en = 1'b0;
            end
            STALL: begin
                bus.pc_en       = 1'b0;
                bus.ifid_en     = 1'b0;
                bus.idex_bubble = 1'b1;
            end
            FLUSH: bus.ifid_flush = 1'b1;
            default: begin
                if (w_redir) begin
                    bus.pc_sel_redirect = 1'b1;
                    bus.ifid_flush      = 1'b1;
                end
            end
        endcase
    end

    // Consecutive-stall watchdog; memory waits neither count nor clear it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 8'd0;
            r_wdog      <= 1'b0;
        end else if (!w_busy) begin
            if (w_stall) begin
                if (r_stall_cnt != 8'hff)
                    r_stall_cnt <= r_stall_cnt + 8'd1;
                if (({1'b0, r_stall_cnt} + 9'd1) >= 9'(MAX_STALL))
                    r_wdog <= 1'b1;
            end else begin
                r_stall_cnt <= 8'd0;
            end
        end
    end

    assign bus.wdog_err = r_wdog;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_perf_stall, r_perf_flush, r_perf_memwait;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
            r_perf_memwait <= '0;
        end else begin
            if (w_eff == STALL && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (bus.ifid_flush && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + 1'b1;
            if (w_busy && r_perf_memwait != '1)
                r_perf_memwait <= r_perf_memwait + 1'b1;
        end
    end

    assign bus.perf_stall   = r_perf_stall;
    assign bus.perf_flush   = r_perf_flush;
    assign bus.perf_memwait = r_perf_memwait;
`endif
endmodule
